instr_stream_encoder: RTL and testbench

//  Encoder counterpart of the control decoder: accepts symbolic instruction requests (mnemonic + fields),

---
 rtl/mips_isa_pkg.sv | 85 ++++++++
 rtl/instr_stream_encoder_if.sv | 26 ++
 rtl/instr_fifo.sv | 62 ++++++
 rtl/instr_stream_encoder.sv | 113 +++++++++++
 tb/tb_instr_stream_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct map shared with the control decoder, request mnemonic codes,
// and the word-assembly function used by the instruction stream encoder.
package mips_isa_pkg;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam logic [5:0] OPC_JAL    = 6'b000011;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_ADDIU  = 6'b001001;
  localparam logic [5:0] OPC_SLTI   = 6'b001010;
  localparam logic [5:0] OPC_ANDI   = 6'b001100;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_LUI    = 6'b001111;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [4:0] {
    REQ_ADD, REQ_ADDU, REQ_SUB, REQ_SUBU, REQ_AND, REQ_OR, REQ_NOR, REQ_SLT,
    REQ_SLL, REQ_SRL, REQ_SRA, REQ_JR, REQ_ANDI, REQ_ORI, REQ_SLTI, REQ_ADDI,
    REQ_ADDIU, REQ_BEQ, REQ_BNE, REQ_BGTZ, REQ_BGEZ, REQ_LW, REQ_SW, REQ_LUI,
    REQ_J, REQ_JAL
  } req_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} enc_state_e;

  function automatic logic op_is_legal(input logic [4:0] op);
    return op <= REQ_JAL;
  endfunction

  function automatic logic [31:0] encode_instr(input logic [4:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] shamt, input logic [15:0] imm,
                                               input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    case (op)
      REQ_ADD:   w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      REQ_ADDU:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
      REQ_SUB:   w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      REQ_SUBU:  w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUBU};
      REQ_AND:   w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      REQ_OR:    w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      REQ_NOR:   w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
      REQ_SLT:   w = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      REQ_SLL:   w = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
      REQ_SRL:   w = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
      REQ_SRA:   w = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
      REQ_JR:    w = {OPC_RTYPE, rs, 15'd0, FN_JR};
      REQ_ANDI:  w = {OPC_ANDI, rs, rt, imm};
      REQ_ORI:   w = {OPC_ORI, rs, rt, imm};
      REQ_SLTI:  w = {OPC_SLTI, rs, rt, imm};
      REQ_ADDI:  w = {OPC_ADDI, rs, rt, imm};
      REQ_ADDIU: w = {OPC_ADDIU, rs, rt, imm};
      REQ_BEQ:   w = {OPC_BEQ, rs, rt, imm};
      REQ_BNE:   w = {OPC_BNE, rs, rt, imm};
      REQ_BGTZ:  w = {OPC_BGTZ, rs, 5'b00000, imm};
      REQ_BGEZ:  w = {OPC_REGIMM, rs, 5'b00001, imm};
      REQ_LW:    w = {OPC_LW, rs, rt, imm};
      REQ_SW:    w = {OPC_SW, rs, rt, imm};
      REQ_LUI:   w = {OPC_LUI, 5'd0, rt, imm};
      REQ_J:     w = {OPC_J, target};
      REQ_JAL:   w = {OPC_JAL, target};
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request and instruction-memory write bus of the instruction stream encoder.
interface instr_stream_encoder_if #(parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [4:0]        req_shamt;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded words between request acceptance and imem write.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & !full;
  assign pop_ok  = pop & !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: encodes symbolic instruction requests into MIPS words and writes
// them sequentially into instruction memory through a small FIFO.
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   finish,
  instr_stream_encoder_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err_illegal,
  output logic [ADDR_W:0]        words_written
);
  // state | meaning
  // IDLE  | waiting for start, no writes
  // RUN   | accepting requests and writing imem
  // DRAIN | finish seen, writing out remaining FIFO words
  // DONE  | one-cycle completion pulse
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   SLOTS_INIT = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   slots_q, slots_d;
  logic              err_q, err_d;
  logic              fifo_full, fifo_empty, accept, legal, push, pop, req_ready, imem_we;
  logic [31:0]       enc_word, fifo_head;

  assign legal     = op_is_legal(bus.req_op);
  assign enc_word  = encode_instr(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd,
                                  bus.req_shamt, bus.req_imm, bus.req_target);
  assign req_ready = (state_q == S_RUN) & !fifo_full & (slots_q != '0);
  assign imem_we   = !fifo_empty & ((state_q == S_RUN) | (state_q == S_DRAIN));
  assign accept    = bus.req_valid & req_ready;
  assign push      = accept & legal;
  assign pop       = imem_we & bus.imem_ready;

  assign bus.req_ready  = req_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = fifo_head;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err_illegal    = err_q;
  assign words_written  = words_q;

  instr_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    slots_d = slots_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        addr_d  = BASE;
        words_d = '0;
        slots_d = SLOTS_INIT;
        err_d   = 1'b0;
      end
      S_RUN:   if (finish) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      if (legal) slots_d = slots_q - CNT_ONE;
      else       err_d   = 1'b1;
    end
    // The last slot leaves the address parked at the top instead of wrapping.
    if (pop) begin
      addr_d  = (addr_q == ADDR_MAX) ? addr_q : addr_q + ADDR_ONE;
      words_d = words_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      words_q <= '0;
      slots_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      slots_q <= slots_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench: encoding, FIFO backpressure, illegal ops, slot exhaustion and reset abort.
module tb_instr_stream_encoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, finish_a = 1'b0, start_b = 1'b0, finish_b = 1'b0;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [8:0] ww_a;
  logic [2:0] ww_b;
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  sa_addr[$];
  logic [31:0] sa_data[$];
  logic [1:0]  sb_addr[$];
  logic [31:0] sb_data[$];
  logic [31:0] exp_w[$];

  always #5 clock = ~clock;

  instr_stream_encoder_if #(.ADDR_W(8)) a ();
  instr_stream_encoder_if #(.ADDR_W(2)) b ();

  instr_stream_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clock(clock), .reset(reset), .start(start_a), .finish(finish_a), .bus(a),
    .busy(busy_a), .done(done_a), .err_illegal(err_a), .words_written(ww_a));

  instr_stream_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clock(clock), .reset(reset), .start(start_b), .finish(finish_b), .bus(b),
    .busy(busy_b), .done(done_b), .err_illegal(err_b), .words_written(ww_b));

  // Transfers complete at the next rising edge when we&ready hold at the falling edge.
  always @(negedge clock) begin
    if (!reset && a.imem_we && a.imem_ready) begin
      sa_addr.push_back(a.imem_addr);
      sa_data.push_back(a.imem_wdata);
    end
    if (!reset && b.imem_we && b.imem_ready) begin
      sb_addr.push_back(b.imem_addr);
      sb_data.push_back(b.imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic [4:0] op, rs, rt, rd, sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    a.req_op = op; a.req_rs = rs; a.req_rt = rt; a.req_rd = rd;
    a.req_shamt = sh; a.req_imm = imm; a.req_target = tgt;
  endtask

  task automatic send_a(input logic [4:0] op, rs, rt, rd, sh, input logic [15:0] imm,
                        input logic [25:0] tgt);
    set_a(op, rs, rt, rd, sh, imm, tgt);
    a.req_valid = 1'b1;
    for (int i = 0; i < 50 && !a.req_ready; i++) tick();
    n_cmp++;
    if (a.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready_timeout: req_ready=%b required 1 (op %0d)", a.req_ready, op);
    end
    tick();
    a.req_valid = 1'b0;
  endtask

  task automatic start_session_a();
    sa_addr.delete(); sa_data.delete(); exp_w.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic end_session_a(input int exp_ww);
    finish_a = 1'b1;
    tick();
    finish_a = 1'b0;
    for (int i = 0; i < 60 && !done_a; i++) tick();
    n_cmp++;
    if (done_a !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout: done=%b required 1", done_a);
    end
    n_cmp++;
    if (ww_a !== 9'(exp_ww)) begin
      n_bad++;
      $display("FAIL words_written: got %0d required %0d", ww_a, exp_ww);
    end
    tick();
    n_cmp++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: done=%b busy=%b required 0 0", done_a, busy_a);
    end
    n_cmp++;
    if (sa_data.size() != exp_w.size()) begin
      n_bad++;
      $display("FAIL write_count: got %0d required %0d", sa_data.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < sa_data.size(); i++) begin
      n_cmp++;
      if (sa_data[i] !== exp_w[i] || sa_addr[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL write_%0d: got addr %0d data %h required addr %0d data %h",
                 i, sa_addr[i], sa_data[i], i, exp_w[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (busy_a !== 0 || done_a !== 0 || err_a !== 0 || ww_a !== 0) begin
      n_bad++;
      $display("FAIL reset_status: busy=%b done=%b err=%b ww=%0d required 0 0 0 0",
               busy_a, done_a, err_a, ww_a);
    end
    n_cmp++;
    if (a.imem_we !== 0 || a.req_ready !== 0 || a.imem_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_bus: we=%b ready=%b addr=%0d required 0 0 0",
               a.imem_we, a.req_ready, a.imem_addr);
    end
    n_cmp++;
    if (busy_b !== 0 || b.imem_we !== 0 || b.req_ready !== 0 || ww_b !== 0) begin
      n_bad++;
      $display("FAIL reset_small: busy=%b we=%b ready=%b ww=%0d required 0 0 0 0",
               busy_b, b.imem_we, b.req_ready, ww_b);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_encode();
    a.imem_ready = 1'b1;
    start_session_a();
    n_cmp++;
    if (busy_a !== 1'b1 || a.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_run: busy=%b ready=%b required 1 1", busy_a, a.req_ready);
    end
    send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);   // ADD, shamt forced to 0
    n_cmp++;
    if (a.imem_we !== 1'b1 || a.imem_wdata !== 32'h00221820 || a.imem_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL add_latency: we=%b data=%h addr=%0d required 1 00221820 0",
               a.imem_we, a.imem_wdata, a.imem_addr);
    end
    send_a(5'd15, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0);  // ADDI
    send_a(5'd8, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);      // SLL, rs forced to 0
    send_a(5'd20, 5'd4, 5'd9, 5'd0, 5'd0, 16'h0003, 26'h0);  // BGEZ, rt forced to 1
    send_a(5'd23, 5'd5, 5'd3, 5'd0, 5'd0, 16'hABCD, 26'h0);  // LUI
    send_a(5'd19, 5'd2, 5'd7, 5'd0, 5'd0, 16'h0001, 26'h0);  // BGTZ
    send_a(5'd10, 5'd9, 5'd4, 5'd5, 5'd31, 16'h0, 26'h0);    // SRA
    exp_w = '{32'h00221820, 32'h2008FFFF, 32'h00021900, 32'h04810003,
              32'h3C03ABCD, 32'h1C400001, 32'h00042FC3};
    end_session_a(7);
  endtask

  task automatic test_jumps();
    a.imem_ready = 1'b1;
    start_session_a();
    n_cmp++;
    if (ww_a !== 9'd0 || a.imem_addr !== 8'd0) begin
      n_bad++;
      $display("FAIL restart_counters: ww=%0d addr=%0d required 0 0", ww_a, a.imem_addr);
    end
    send_a(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    send_a(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    exp_w = '{32'h08000010, 32'h0C000010};
    end_session_a(2);
  endtask

  task automatic test_back_to_back();
    int acc;
    logic hit;
    start_session_a();
    a.imem_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (acc < 6) begin
        set_a(5'd15, 5'd0, 5'(acc), 5'd0, 5'd0, 16'(acc), 26'h0);
        a.req_valid = 1'b1;
      end else a.req_valid = 1'b0;
      hit = a.req_valid & a.req_ready;
      tick();
      if (hit) acc++;
    end
    a.req_valid = 1'b0;
    n_cmp++;
    if (acc !== 4 || a.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_full_accepts: accepted %0d ready=%b required 4 0", acc, a.req_ready);
    end
    n_cmp++;
    if (a.imem_we !== 1'b1 || a.imem_addr !== 8'd0 || a.imem_wdata !== 32'h20000000) begin
      n_bad++;
      $display("FAIL held_write: we=%b addr=%0d data=%h required 1 0 20000000",
               a.imem_we, a.imem_addr, a.imem_wdata);
    end
    a.imem_ready = 1'b1;
    send_a(5'd15, 5'd0, 5'd4, 5'd0, 5'd0, 16'd4, 26'h0);
    send_a(5'd15, 5'd0, 5'd5, 5'd0, 5'd0, 16'd5, 26'h0);
    exp_w = '{32'h20000000, 32'h20010001, 32'h20020002, 32'h20030003,
              32'h20040004, 32'h20050005};
    end_session_a(6);
  endtask

  task automatic test_illegal();
    a.imem_ready = 1'b1;
    start_session_a();
    send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    send_a(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0);
    n_cmp++;
    if (err_a !== 1'b1) begin
      n_bad++;
      $display("FAIL err_illegal_set: got %b required 1", err_a);
    end
    send_a(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0);  // ORI
    exp_w = '{32'h00221820, 32'h34221234};
    end_session_a(2);
    n_cmp++;
    if (err_a !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b required 1", err_a);
    end
    start_session_a();
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear_on_start: got %b required 0", err_a);
    end
    end_session_a(0);
  endtask

  task automatic test_slots_exhausted();
    int acc;
    logic hit;
    sb_addr.delete(); sb_data.delete();
    b.imem_ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (acc < 5) begin
        b.req_op = 5'd0; b.req_rs = 5'd0; b.req_rt = 5'd0; b.req_rd = 5'(acc + 1);
        b.req_shamt = 5'd0; b.req_imm = 16'h0; b.req_target = 26'h0;
        b.req_valid = 1'b1;
      end else b.req_valid = 1'b0;
      hit = b.req_valid & b.req_ready;
      tick();
      if (hit) acc++;
    end
    n_cmp++;
    if (acc !== 4 || b.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL slots_accepts: accepted %0d ready=%b required 4 0", acc, b.req_ready);
    end
    b.req_valid = 1'b0;
    finish_b = 1'b1;
    tick();
    finish_b = 1'b0;
    for (int i = 0; i < 60 && !done_b; i++) tick();
    n_cmp++;
    if (done_b !== 1'b1 || ww_b !== 3'd4) begin
      n_bad++;
      $display("FAIL small_done: done=%b ww=%0d required 1 4", done_b, ww_b);
    end
    n_cmp++;
    if (sb_data.size() != 4) begin
      n_bad++;
      $display("FAIL small_write_count: got %0d required 4", sb_data.size());
    end
    for (int i = 0; i < 4 && i < sb_data.size(); i++) begin
      n_cmp++;
      if (sb_addr[i] !== 2'(i) || sb_data[i] !== ((32'(i + 1) << 11) | 32'h20)) begin
        n_bad++;
        $display("FAIL small_write_%0d: got addr %0d data %h required addr %0d data %h",
                 i, sb_addr[i], sb_data[i], i, (32'(i + 1) << 11) | 32'h20);
      end
    end
    tick();
  endtask

  task automatic test_reset_in_drain();
    logic seen;
    b.imem_ready = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b.req_op = 5'd1; b.req_rd = 5'(k + 1); b.req_valid = 1'b1;
      tick();
    end
    b.req_valid = 1'b0;
    finish_b = 1'b1;
    tick();
    finish_b = 1'b0;
    n_cmp++;
    if (busy_b !== 1'b1 || b.imem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_pending: busy=%b we=%b required 1 1", busy_b, b.imem_we);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b.imem_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= b.imem_we;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0 || busy_b !== 1'b0 || b.imem_addr !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_abort: we_seen=%b busy=%b addr=%0d required 0 0 0",
               seen, busy_b, b.imem_addr);
    end
  endtask

  initial begin
    a.req_valid = 0; a.req_op = 0; a.req_rs = 0; a.req_rt = 0; a.req_rd = 0;
    a.req_shamt = 0; a.req_imm = 0; a.req_target = 0; a.imem_ready = 0;
    b.req_valid = 0; b.req_op = 0; b.req_rs = 0; b.req_rt = 0; b.req_rd = 0;
    b.req_shamt = 0; b.req_imm = 0; b.req_target = 0; b.imem_ready = 0;
    test_reset();
    test_encode();
    test_jumps();
    test_back_to_back();
    test_illegal();
    test_slots_exhausted();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
